// File: rtl/network_bf_in_pkg.sv
// Shared definitions for the CFNTT memory/butterfly network: bank count, select
// encoding and the default bank read latency.
package network_bf_in_pkg;

  localparam int NUM_BANKS      = 4;
  localparam int SEL_W          = 2;
  localparam int RD_LAT_DEFAULT = 1;

  // Bank-select encoding, shared with the write-side network and address generator.
  localparam logic [SEL_W-1:0] SEL_Q0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_Q1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_Q2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_Q3 = 2'd3;

  // Delay-line word: {valid, sel lane3, sel lane2, sel lane1, sel lane0}.
  localparam int TAG_W = 1 + NUM_BANKS * SEL_W;

  typedef logic [NUM_BANKS-1:0][SEL_W-1:0] lane_sel_t;

  function automatic logic sel_conflict(input lane_sel_t sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      for (int j = i + 1; j < NUM_BANKS; j++) begin
        if (sel[i] == sel[j]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/network_bf_in_sel_delay_line.sv
// Shift register that carries the {valid, selects} word so it lines up with the
// bank read data. Synchronous active-low reset clears every stage.
module sel_delay_line #(
  parameter int width = 9,
  parameter int depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [width-1:0] data_i,
  output logic [width-1:0] data_o
);

  logic [depth-1:0][width-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[depth-1];

endmodule

// File: rtl/network_bf_in.sv
// Read-side crossbar: routes bank read ports q0..q3 onto the butterfly inputs using
// selects delayed by the bank read latency, and keeps a sticky bank-conflict flag.
module network_bf_in
  import network_bf_in_pkg::*;
#(
  parameter int data_width = 14,
  parameter int RD_LAT     = RD_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [SEL_W-1:0]      sel_b_0,
  input  logic [SEL_W-1:0]      sel_b_1,
  input  logic [SEL_W-1:0]      sel_b_2,
  input  logic [SEL_W-1:0]      sel_b_3,
  input  logic [data_width-1:0] q0,
  input  logic [data_width-1:0] q1,
  input  logic [data_width-1:0] q2,
  input  logic [data_width-1:0] q3,
  input  logic                  err_clr,
  output logic [data_width-1:0] bf_0_upper,
  output logic [data_width-1:0] bf_0_lower,
  output logic [data_width-1:0] bf_1_upper,
  output logic [data_width-1:0] bf_1_lower,
  output logic                  out_valid,
  output logic                  conflict
);

  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_d;
  logic             v_d;
  lane_sel_t        sel_d;

  assign tag_in = {in_valid, sel_b_3, sel_b_2, sel_b_1, sel_b_0};

  sel_delay_line #(
    .width (TAG_W),
    .depth (RD_LAT)
  ) u_sel_delay (
    .clk_i  (clk),
    .rst_ni (rst),
    .data_i (tag_in),
    .data_o (tag_d)
  );

  assign v_d   = tag_d[TAG_W-1];
  assign sel_d = tag_d[TAG_W-2:0];

  logic [NUM_BANKS-1:0][data_width-1:0] route_d;
  logic [NUM_BANKS-1:0][data_width-1:0] bf_q;
  logic [NUM_BANKS-1:0][data_width-1:0] bf_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 conflict_q, conflict_d;

  always_comb begin
    route_d = '0;
    for (int l = 0; l < NUM_BANKS; l++) begin
      case (sel_d[l])
        SEL_Q0:  route_d[l] = q0;
        SEL_Q1:  route_d[l] = q1;
        SEL_Q2:  route_d[l] = q2;
        SEL_Q3:  route_d[l] = q3;
        default: route_d[l] = q0;
      endcase
    end
  end

  // A fresh conflict outranks a same-cycle clear so no error is ever lost.
  always_comb begin
    bf_d        = bf_q;
    out_valid_d = v_d;
    conflict_d  = conflict_q;
    if (v_d) bf_d = route_d;
    if (err_clr) conflict_d = 1'b0;
    if (v_d && sel_conflict(sel_d)) conflict_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bf_q        <= '0;
      out_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      bf_q        <= bf_d;
      out_valid_q <= out_valid_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bf_0_upper = bf_q[0];
  assign bf_0_lower = bf_q[1];
  assign bf_1_upper = bf_q[2];
  assign bf_1_lower = bf_q[3];
  assign out_valid  = out_valid_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_network_bf_in.sv
// Drives three crossbar instances (read latency 1, 2, 3) from one stimulus stream and
// compares every cycle against a history-based model of the routing rules.
module tb_network_bf_in;

  localparam int DW   = 14;
  localparam int NL   = 3;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [1:0]    sel_b_0, sel_b_1, sel_b_2, sel_b_3;
  logic [DW-1:0] q0, q1, q2, q3;
  logic          err_clr;

  logic [DW-1:0] bf0u [NL];
  logic [DW-1:0] bf0l [NL];
  logic [DW-1:0] bf1u [NL];
  logic [DW-1:0] bf1l [NL];
  logic          ov   [NL];
  logic          conf [NL];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    network_bf_in #(.data_width(DW), .RD_LAT(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .sel_b_0    (sel_b_0),
      .sel_b_1    (sel_b_1),
      .sel_b_2    (sel_b_2),
      .sel_b_3    (sel_b_3),
      .q0         (q0),
      .q1         (q1),
      .q2         (q2),
      .q3         (q3),
      .err_clr    (err_clr),
      .bf_0_upper (bf0u[g]),
      .bf_0_lower (bf0l[g]),
      .bf_1_upper (bf1u[g]),
      .bf_1_lower (bf1l[g]),
      .out_valid  (ov[g]),
      .conflict   (conf[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus history, indexed by cycle number.
  logic          iv_h  [MAXC];
  logic          rst_h [MAXC];
  logic          clr_h [MAXC];
  logic [1:0]    sel_h [MAXC][4];
  logic [DW-1:0] q_h   [MAXC][4];

  logic [4*DW-1:0] e_bf   [NL];
  logic            e_conf [NL];
  logic            e_ov   [NL];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic has_dup(input int s);
    logic d;
    d = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (sel_h[s][i] == sel_h[s][j]) d = 1'b1;
    return d;
  endfunction

  // Outputs seen in cycle n: beat issued in cycle n-L-1, routing data presented in n-1.
  task automatic model_and_check();
    int  n, s;
    logic alive;
    n = cyc;
    for (int g = 0; g < NL; g++) begin
      if (!rst_h[n-1]) begin
        e_bf[g] = '0; e_ov[g] = 1'b0; e_conf[g] = 1'b0;
      end else begin
        s = n - 1 - (g + 1);
        alive = (s >= 0) && iv_h[s];
        for (int k = (s < 0 ? 0 : s); alive && k <= n - 2; k++)
          if (!rst_h[k]) alive = 1'b0;
        e_ov[g] = alive;
        if (clr_h[n-1]) e_conf[g] = 1'b0;
        if (alive) begin
          e_bf[g] = {q_h[n-1][sel_h[s][0]], q_h[n-1][sel_h[s][1]],
                     q_h[n-1][sel_h[s][2]], q_h[n-1][sel_h[s][3]]};
          if (has_dup(s)) e_conf[g] = 1'b1;
        end
      end
      check($sformatf("out_valid_L%0d", g + 1), 64'(ov[g]), 64'(e_ov[g]));
      check($sformatf("conflict_L%0d", g + 1), 64'(conf[g]), 64'(e_conf[g]));
      check($sformatf("bf_L%0d", g + 1), 64'({bf0u[g], bf0l[g], bf1u[g], bf1l[g]}),
            64'(e_bf[g]));
    end
  endtask

  task automatic step();
    iv_h[cyc]  = in_valid;
    rst_h[cyc] = rst;
    clr_h[cyc] = err_clr;
    sel_h[cyc][0] = sel_b_0; sel_h[cyc][1] = sel_b_1;
    sel_h[cyc][2] = sel_b_2; sel_h[cyc][3] = sel_b_3;
    q_h[cyc][0] = q0; q_h[cyc][1] = q1; q_h[cyc][2] = q2; q_h[cyc][3] = q3;
    @(posedge clk);
    #1;
    cyc++;
    model_and_check();
  endtask

  task automatic set_beat(input logic v, input logic [1:0] a, b, c, d);
    in_valid = v; sel_b_0 = a; sel_b_1 = b; sel_b_2 = c; sel_b_3 = d;
  endtask

  task automatic set_q(input int a, b, c, d);
    q0 = DW'(a); q1 = DW'(b); q2 = DW'(c); q3 = DW'(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_beat(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
      set_q(i, i + 1, i + 2, i + 3);
      step();
    end
  endtask

  initial begin
    rst = 1'b0; err_clr = 1'b0;
    set_beat(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    set_q(0, 0, 0, 0);
    step(); step();
    rst = 1'b1;
    idle(2);

    // Identity route.
    set_beat(1'b1, 2'd0, 2'd1, 2'd2, 2'd3); set_q(1, 2, 3, 4); step();
    set_beat(1'b0, 2'd0, 2'd0, 2'd0, 2'd0); set_q(10, 20, 30, 40); step();
    check("id_b0u", 64'(bf0u[0]), 64'd10);
    check("id_b0l", 64'(bf0l[0]), 64'd20);
    check("id_b1u", 64'(bf1u[0]), 64'd30);
    check("id_b1l", 64'(bf1l[0]), 64'd40);
    check("id_ov",  64'(ov[0]),   64'd1);
    idle(4);

    // Back-to-back permutations.
    set_beat(1'b1, 2'd3, 2'd2, 2'd1, 2'd0); set_q(100, 101, 102, 103); step();
    set_beat(1'b1, 2'd1, 2'd0, 2'd3, 2'd2); set_q(104, 105, 106, 107); step();
    set_beat(1'b1, 2'd2, 2'd3, 2'd0, 2'd1); set_q(108, 109, 110, 111); step();
    set_beat(1'b1, 2'd0, 2'd1, 2'd2, 2'd3); set_q(112, 113, 114, 115); step();
    idle(5);

    // Conflict, sticky over clean beats, clear, then clear coinciding with new conflict.
    set_beat(1'b1, 2'd2, 2'd2, 2'd0, 2'd1); set_q(1, 2, 3, 4); step();
    set_beat(1'b0, 2'd0, 2'd0, 2'd0, 2'd0); set_q(50, 51, 52, 53); step();
    check("cf_dup_u", 64'(bf0u[0]), 64'd52);
    check("cf_dup_l", 64'(bf0l[0]), 64'd52);
    for (int i = 0; i < 10; i++) begin
      set_beat(1'b1, 2'(i), 2'(i + 1), 2'(i + 2), 2'(i + 3));
      set_q(200 + i, 300 + i, 400 + i, 500 + i);
      step();
    end
    idle(4);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    idle(1);
    set_beat(1'b1, 2'd1, 2'd3, 2'd3, 2'd0); step();
    set_beat(1'b0, 2'd0, 2'd0, 2'd0, 2'd0); err_clr = 1'b1; step(); err_clr = 1'b0;
    check("clr_vs_new", 64'(conf[0]), 64'd1);
    idle(4);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;

    // Duplicate selects with no valid beat.
    for (int i = 0; i < 5; i++) begin
      set_beat(1'b0, 2'd1, 2'd1, 2'd1, 2'd1); set_q(i, i, i, i); step();
    end
    idle(4);

    // Reset mid-stream.
    set_beat(1'b1, 2'd3, 2'd1, 2'd0, 2'd2); set_q(7, 8, 9, 10); step();
    set_beat(1'b1, 2'd0, 2'd2, 2'd1, 2'd3); set_q(11, 12, 13, 14); step();
    set_beat(1'b0, 2'd0, 2'd0, 2'd0, 2'd0); rst = 1'b0; step(); rst = 1'b1;
    step();
    set_beat(1'b1, 2'd1, 2'd2, 2'd3, 2'd0); set_q(21, 22, 23, 24); step();
    idle(5);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] p [4];
      if ($urandom_range(1, 0) == 1) begin
        int r;
        r = $urandom_range(3, 0);
        for (int k = 0; k < 4; k++) p[k] = 2'(k + r);
        if ($urandom_range(1, 0) == 1) begin p[0] = p[1] ^ 2'd1; p[1] = p[1]; end
      end else begin
        for (int k = 0; k < 4; k++) p[k] = 2'($urandom_range(3, 0));
      end
      set_beat($urandom_range(9, 0) < 7, p[0], p[1], p[2], p[3]);
      set_q($urandom_range(16383, 0), $urandom_range(16383, 0),
            $urandom_range(16383, 0), $urandom_range(16383, 0));
      err_clr = ($urandom_range(7, 0) == 0);
      rst     = ($urandom_range(99, 0) != 0);
      step();
    end
    rst = 1'b1; err_clr = 1'b0;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
